// File: rtl/wb_arbiter_if.sv
// Writeback bus between the execution units (mul, ALU/misc, mem) and the
// writeback scheduler. The scheduler uses the slave view; the units, or a
// bench, use the master view.
//
// Handshake: a unit presents a completion by driving x_wb_oper=1 together with
// regdest/writereg/wbvalue. The completion is taken on the rising clock edge
// where x_wb_oper=1 and x_wb_ready=1. x_wb_ready depends only on the
// scheduler's registered state, never combinationally on x_wb_oper. Driving
// x_wb_oper=1 while x_wb_ready=0 is a protocol error, and that completion is
// ignored.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              mul_wb_oper;
  logic [ADDR_W-1:0] mul_wb_regdest;
  logic              mul_wb_writereg;
  logic [DATA_W-1:0] mul_wb_wbvalue;
  logic              mul_wb_ready;

  logic              am_wb_oper;
  logic [ADDR_W-1:0] am_wb_regdest;
  logic              am_wb_writereg;
  logic [DATA_W-1:0] am_wb_wbvalue;
  logic              am_wb_ready;

  logic              mem_wb_oper;
  logic [ADDR_W-1:0] mem_wb_regdest;
  logic              mem_wb_writereg;
  logic [DATA_W-1:0] mem_wb_wbvalue;
  logic              mem_wb_ready;

  logic              wb_reg_en;
  logic [ADDR_W-1:0] wb_reg_addr;
  logic [DATA_W-1:0] wb_reg_data;
  logic              wb_busy;

  modport slave (
    input  mul_wb_oper, mul_wb_regdest, mul_wb_writereg, mul_wb_wbvalue,
    input  am_wb_oper, am_wb_regdest, am_wb_writereg, am_wb_wbvalue,
    input  mem_wb_oper, mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue,
    output mul_wb_ready, am_wb_ready, mem_wb_ready,
    output wb_reg_en, wb_reg_addr, wb_reg_data, wb_busy
  );

  modport master (
    output mul_wb_oper, mul_wb_regdest, mul_wb_writereg, mul_wb_wbvalue,
    output am_wb_oper, am_wb_regdest, am_wb_writereg, am_wb_wbvalue,
    output mem_wb_oper, mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue,
    input  mul_wb_ready, am_wb_ready, mem_wb_ready,
    input  wb_reg_en, wb_reg_addr, wb_reg_data, wb_busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback scheduler. Each of the three units gets a small completion FIFO.
// A round-robin arbiter drains at most one FIFO head per cycle into a
// registered register-file write port. Source order is mul=0, am=1, mem=2.
module wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NSRC  = 3;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [NSRC-1:0]   src_oper;
  logic [NSRC-1:0]   src_writereg;
  logic [ADDR_W-1:0] src_regdest [NSRC];
  logic [DATA_W-1:0] src_wbvalue [NSRC];

  logic [ADDR_W-1:0] fifo_addr [NSRC][DEPTH];
  logic [DATA_W-1:0] fifo_data [NSRC][DEPTH];
  logic [PTR_W-1:0]  rd_ptr    [NSRC];
  logic [PTR_W-1:0]  wr_ptr    [NSRC];
  logic [CNT_W-1:0]  count     [NSRC];
  logic [CNT_W-1:0]  count_nxt [NSRC];

  logic [NSRC-1:0]   ready_q;
  logic [NSRC-1:0]   nonempty;
  logic [NSRC-1:0]   store;
  logic [NSRC-1:0]   grant;
  logic [1:0]        grant_idx;
  logic [1:0]        cand;
  logic [1:0]        last_grant;

  logic              wb_reg_en_q;
  logic [ADDR_W-1:0] wb_reg_addr_q;
  logic [DATA_W-1:0] wb_reg_data_q;

  assign src_oper       = {bus.mem_wb_oper, bus.am_wb_oper, bus.mul_wb_oper};
  assign src_writereg   = {bus.mem_wb_writereg, bus.am_wb_writereg, bus.mul_wb_writereg};
  assign src_regdest[0] = bus.mul_wb_regdest;
  assign src_regdest[1] = bus.am_wb_regdest;
  assign src_regdest[2] = bus.mem_wb_regdest;
  assign src_wbvalue[0] = bus.mul_wb_wbvalue;
  assign src_wbvalue[1] = bus.am_wb_wbvalue;
  assign src_wbvalue[2] = bus.mem_wb_wbvalue;

  assign bus.mul_wb_ready = ready_q[0];
  assign bus.am_wb_ready  = ready_q[1];
  assign bus.mem_wb_ready = ready_q[2];
  assign bus.wb_reg_en    = wb_reg_en_q;
  assign bus.wb_reg_addr  = wb_reg_addr_q;
  assign bus.wb_reg_data  = wb_reg_data_q;
  assign bus.wb_busy      = (|nonempty) | wb_reg_en_q;

  // Accepted completions that write no register (writereg=0 or x0) are dropped here.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      nonempty[i] = (count[i] != '0);
      store[i]    = src_oper[i] & ready_q[i] & src_writereg[i] & (src_regdest[i] != '0);
    end
  end

  // Round-robin: the first non-empty source after the last grant wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NSRC; k++) begin
      cand = 2'((32'(last_grant) + 32'(k)) % NSRC);
      if (grant == '0 && nonempty[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next occupancy: enqueue and dequeue in the same cycle cancel out.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      count_nxt[i] = count[i];
      if (store[i] && !grant[i]) begin
        count_nxt[i] = count[i] + CNT_W'(1);
      end else if (!store[i] && grant[i]) begin
        count_nxt[i] = count[i] - CNT_W'(1);
      end
    end
  end

  // Per-source pointers and occupancy. Ready is registered from the next
  // occupancy, so a full FIFO stays not-ready for the cycle it drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ready_q <= '1;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (store[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i]   <= count_nxt[i];
        ready_q[i] <= (count_nxt[i] != FULL_CNT);
      end
    end
  end

  // Entry storage. Unreset because a slot is only read while counted valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NSRC; i++) begin
      if (store[i]) begin
        fifo_addr[i][wr_ptr[i]] <= src_regdest[i];
        fifo_data[i][wr_ptr[i]] <= src_wbvalue[i];
      end
    end
  end

  // Registered write port and round-robin history. After reset mem counts as
  // the last grant, so mul is served first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_reg_en_q   <= 1'b0;
      wb_reg_addr_q <= '0;
      wb_reg_data_q <= '0;
      last_grant    <= 2'd2;
    end else begin
      wb_reg_en_q <= |grant;
      if (|grant) begin
        wb_reg_addr_q <= fifo_addr[grant_idx][rd_ptr[grant_idx]];
        wb_reg_data_q <= fifo_data[grant_idx][rd_ptr[grant_idx]];
        last_grant    <= grant_idx;
      end else begin
        wb_reg_addr_q <= '0;
        wb_reg_data_q <= '0;
      end
    end
  end

  // A unit must never offer a completion while its FIFO refuses it.
  mul_no_overrun: assert property (@(posedge clock) disable iff (reset) !(src_oper[0] && !ready_q[0]));
  am_no_overrun:  assert property (@(posedge clock) disable iff (reset) !(src_oper[1] && !ready_q[1]));
  mem_no_overrun: assert property (@(posedge clock) disable iff (reset) !(src_oper[2] && !ready_q[2]));
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter. A queue-based model of the three completion FIFOs and
// the round-robin pointer predicts the write port, ready and busy outputs each
// cycle. Directed phases add literal expectations.
module tb_wb_arbiter;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT hookup ----------------
  wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [2:0]        t_oper;
  logic [2:0]        t_wr;
  logic [ADDR_W-1:0] t_rd  [3];
  logic [DATA_W-1:0] t_val [3];
  logic [2:0]        d_rdy;

  assign bus.mul_wb_oper     = t_oper[0];
  assign bus.mul_wb_writereg = t_wr[0];
  assign bus.mul_wb_regdest  = t_rd[0];
  assign bus.mul_wb_wbvalue  = t_val[0];
  assign bus.am_wb_oper      = t_oper[1];
  assign bus.am_wb_writereg  = t_wr[1];
  assign bus.am_wb_regdest   = t_rd[1];
  assign bus.am_wb_wbvalue   = t_val[1];
  assign bus.mem_wb_oper     = t_oper[2];
  assign bus.mem_wb_writereg = t_wr[2];
  assign bus.mem_wb_regdest  = t_rd[2];
  assign bus.mem_wb_wbvalue  = t_val[2];
  assign d_rdy = {bus.mem_wb_ready, bus.am_wb_ready, bus.mul_wb_ready};

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit check_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ent_t              exp_q [3][$];
  int                m_last;
  logic              m_en;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        m_rdy;
  ent_t              m_ent;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) exp_q[i].delete();
      m_last = 2;
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      for (int i = 0; i < 3; i++) m_rdy[i] = (exp_q[i].size() < DEPTH);
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
      for (int k = 1; k <= 3; k++) begin
        int s;
        s = (m_last + k) % 3;
        if (!m_en && exp_q[s].size() != 0) begin
          m_ent  = exp_q[s].pop_front();
          m_en   = 1'b1;
          m_addr = m_ent.a;
          m_data = m_ent.d;
          m_last = s;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (t_oper[i] && m_rdy[i] && t_wr[i] && t_rd[i] != '0)
          exp_q[i].push_back('{a: t_rd[i], d: t_val[i]});
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (check_on && !reset) begin
      chk("wb_reg_en", bus.wb_reg_en, m_en);
      chk("wb_reg_addr", bus.wb_reg_addr, m_addr);
      chk("wb_reg_data", bus.wb_reg_data, m_data);
      chk("wb_busy", bus.wb_busy,
          m_en || exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0);
      chk("mul_wb_ready", bus.mul_wb_ready, exp_q[0].size() < DEPTH);
      chk("am_wb_ready", bus.am_wb_ready, exp_q[1].size() < DEPTH);
      chk("mem_wb_ready", bus.mem_wb_ready, exp_q[2].size() < DEPTH);
    end
  end

  // ---------------- write monitor ----------------
  int wr_cnt = 0;
  int b_cnt  = 0;
  always @(negedge clock) begin
    if (check_on && !reset && bus.wb_reg_en) begin
      wr_cnt++;
      if (bus.wb_reg_addr == 5'd14) b_cnt++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic set_src(input int i, input logic wr, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] val);
    t_oper[i] = 1'b1;
    t_wr[i]   = wr;
    t_rd[i]   = rd;
    t_val[i]  = val;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 40 && bus.wb_busy; k++) @(negedge clock);
    chk(name, bus.wb_busy, 1'b0);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  int          acc;
  int          w0;
  int          viol;
  logic [4:0]  prev_a;
  logic [4:0]  first_a;
  logic [2:0]  seen_full;

  initial begin
    t_oper = '0;
    t_wr   = '0;
    for (int i = 0; i < 3; i++) begin
      t_rd[i]  = '0;
      t_val[i] = '0;
    end
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    check_on = 1'b1;
    @(negedge clock);

    // Reset values
    chk("rst_en", bus.wb_reg_en, 1'b0);
    chk("rst_addr", bus.wb_reg_addr, 5'd0);
    chk("rst_data", bus.wb_reg_data, 32'd0);
    chk("rst_busy", bus.wb_busy, 1'b0);
    chk("rst_ready", d_rdy, 3'b111);

    // Single am write, x3 = DEADBEEF: visible two cycles later for one cycle
    set_src(1, 1'b1, 5'd3, 32'hDEADBEEF);
    @(negedge clock);
    t_oper = '0;
    chk("single_n1_en", bus.wb_reg_en, 1'b0);
    chk("single_n1_busy", bus.wb_busy, 1'b1);
    @(negedge clock);
    chk("single_n2_en", bus.wb_reg_en, 1'b1);
    chk("single_n2_addr", bus.wb_reg_addr, 5'd3);
    chk("single_n2_data", bus.wb_reg_data, 32'hDEADBEEF);
    chk("single_n2_busy", bus.wb_busy, 1'b1);
    @(negedge clock);
    chk("single_n3_en", bus.wb_reg_en, 1'b0);
    chk("single_n3_busy", bus.wb_busy, 1'b0);

    // Simultaneous finish after reset: mul first, then am, then mem
    do_reset();
    set_src(0, 1'b1, 5'd5, 32'd1);
    set_src(1, 1'b1, 5'd6, 32'd2);
    set_src(2, 1'b1, 5'd7, 32'd3);
    @(negedge clock);
    t_oper = '0;
    chk("simul_n1_en", bus.wb_reg_en, 1'b0);
    @(negedge clock);
    chk("simul_w1", {bus.wb_reg_en, bus.wb_reg_addr, bus.wb_reg_data}, {1'b1, 5'd5, 32'd1});
    @(negedge clock);
    chk("simul_w2", {bus.wb_reg_en, bus.wb_reg_addr, bus.wb_reg_data}, {1'b1, 5'd6, 32'd2});
    @(negedge clock);
    chk("simul_w3", {bus.wb_reg_en, bus.wb_reg_addr, bus.wb_reg_data}, {1'b1, 5'd7, 32'd3});
    @(negedge clock);
    chk("simul_idle_en", bus.wb_reg_en, 1'b0);

    // Fairness: mul and mem offer whenever ready, grants must alternate
    viol    = 0;
    prev_a  = '0;
    first_a = '0;
    for (int c = 0; c < 24; c++) begin
      t_oper[0] = d_rdy[0];
      t_wr[0]   = 1'b1;
      t_rd[0]   = 5'd10;
      t_val[0]  = 32'h100 + 32'(c);
      t_oper[2] = d_rdy[2];
      t_wr[2]   = 1'b1;
      t_rd[2]   = 5'd20;
      t_val[2]  = 32'h200 + 32'(c);
      @(negedge clock);
      if (bus.wb_reg_en) begin
        if (first_a == '0) first_a = bus.wb_reg_addr;
        else if (bus.wb_reg_addr == prev_a) viol++;
        prev_a = bus.wb_reg_addr;
      end
    end
    t_oper = '0;
    chk("fair_first_is_mul", first_a, 5'd10);
    chk("fair_alternation", viol, 0);
    drain("fair_drain");

    // Backpressure: all three offer whenever ready
    acc       = 0;
    w0        = wr_cnt;
    seen_full = '0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < 3; i++) begin
        t_oper[i] = d_rdy[i];
        t_wr[i]   = 1'b1;
        t_rd[i]   = 5'(21 + i);
        t_val[i]  = (32'(i) << 16) | 32'(c);
        if (!d_rdy[i]) seen_full[i] = 1'b1;
        if (d_rdy[i]) acc++;
      end
      @(negedge clock);
    end
    t_oper = '0;
    drain("bp_drain");
    chk("bp_accept_eq_write", wr_cnt - w0, acc);
    chk("bp_all_filled", seen_full, 3'b111);

    // Discard: a store (writereg=0) and a write to x0
    set_src(2, 1'b0, 5'd9, 32'h1234);
    @(negedge clock);
    chk("disc_ready_a", bus.mem_wb_ready, 1'b1);
    set_src(2, 1'b1, 5'd0, 32'h5678);
    @(negedge clock);
    t_oper = '0;
    chk("disc_ready_b", bus.mem_wb_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk("disc_busy", bus.wb_busy, 1'b0);
      chk("disc_en", bus.wb_reg_en, 1'b0);
      @(negedge clock);
    end

    // Reset mid-operation: one write on the port, one entry still queued
    b_cnt = 0;
    set_src(0, 1'b1, 5'd13, 32'hAAAA0001);
    @(negedge clock);
    set_src(0, 1'b1, 5'd14, 32'hAAAA0002);
    @(negedge clock);
    t_oper = '0;
    chk("rmid_pre_en", bus.wb_reg_en, 1'b1);
    chk("rmid_pre_addr", bus.wb_reg_addr, 5'd13);
    #2 reset = 1'b1;
    #1;
    chk("rmid_en", bus.wb_reg_en, 1'b0);
    chk("rmid_addr", bus.wb_reg_addr, 5'd0);
    chk("rmid_data", bus.wb_reg_data, 32'd0);
    chk("rmid_busy", bus.wb_busy, 1'b0);
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rmid_mul_ready", bus.mul_wb_ready, 1'b1);
    repeat (4) @(negedge clock);
    #1;
    chk("rmid_dropped_entry", b_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end
endmodule
